counter_timer_arbiter: RTL

Shares one CNT_W-bit interval counter between NUM_REQ requesters.
- A requester raises req with a tick length.
- The block grants the counter round-robin, counts from 0 up to the length, pulses done to the owner, then releases.
- Sits beside the 4-bit counter datapath as its scheduler.
- Fully synchronous, single clock domain.

---
 rtl/counter_timer_arbiter_pkg.sv | 22 ++
 rtl/counter_timer_arbiter_rr_arbiter.sv | 31 +++
 rtl/counter_timer_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/counter_timer_arbiter_pkg.sv
// Shared types and helpers for the counter/timer scheduler.
// Optional abort support is enabled by defining COUNTER_TIMER_ABORT_EN.
package counter_timer_pkg;

  localparam int DEF_CNT_W   = 4;
  localparam int DEF_NUM_REQ = 4;
  localparam int MAX_REQ     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/counter_timer_arbiter_rr_arbiter.sv
// Combinational round-robin search: first set request at or above ptr, wrapping.
module rr_arbiter
  import counter_timer_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;
  logic             hit;

  // Walk candidates in rotated order; the first hit is kept.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    hit   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand  = IDX_W'((int'(ptr) + k) % NUM_REQ);
      hit   = !valid && req[cand];
      idx   = hit ? cand : idx;
      valid = valid | hit;
    end
  end

endmodule

// File: rtl/counter_timer_arbiter.sv
// Round-robin scheduler granting one shared interval counter to NUM_REQ requesters.
// Define COUNTER_TIMER_ABORT_EN to add the abort/aborted ports.
module counter_timer_arbiter
  import counter_timer_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_len,
`ifdef COUNTER_TIMER_ABORT_EN
  input  logic                     abort,
  output logic                     aborted,
`endif
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic               arb_valid;
  logic [IDX_W-1:0]   arb_idx;
  logic               abort_s;

`ifdef COUNTER_TIMER_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort_s = abort;
  assign aborted = aborted_q;
`else
  assign abort_s = 1'b0;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  // Next-state and next-output logic for the grant/count/done sequence.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    len_d    = len_q;
    count_d  = count_q;
    grant_d  = grant_q;
    done_d   = done_q;
`ifdef COUNTER_TIMER_ABORT_EN
    aborted_d = aborted_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_RUN;
          owner_d = arb_idx;
          len_d   = req_len[int'(arb_idx)*CNT_W +: CNT_W];
          count_d = '0;
          grant_d = NUM_REQ'(onehot(3'(arb_idx)));
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // The compare stops the count, so an all-ones length never wraps.
        if ((count_q == len_q) || abort_s) begin
          state_d = ST_DONE;
          done_d  = grant_q;
`ifdef COUNTER_TIMER_ABORT_EN
          aborted_d = abort_s;
`endif
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        done_d   = '0;
        count_d  = '0;
        rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
`ifdef COUNTER_TIMER_ABORT_EN
        aborted_d = 1'b0;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        done_d  = '0;
        count_d = '0;
`ifdef COUNTER_TIMER_ABORT_EN
        aborted_d = 1'b0;
`endif
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      len_q    <= '0;
      count_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
`ifdef COUNTER_TIMER_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      len_q    <= len_d;
      count_q  <= count_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef COUNTER_TIMER_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule
